ascii_cmd_receiver: RTL and testbench
=====================================

Name: ascii_cmd_receiver

Overview:
- Line-oriented ASCII command parser that sits between the UART RX byte output and the watch control and timekeeping logic.
- Collects received bytes into a line buffer. On '\n' it decodes one of five commands: "TIME?", "RUN", "STOP", "CLR", "SET HH:MM:SS:CC".
- Emits one-cycle command pulses and, for SET, a validated 8-digit BCD time.
- A TIME? request is intended to drive the start input of the time-report sender.

Parameters:
- MAX_LEN, 16, line buffer depth in bytes, excluding '\n'; must be at least 15 so SET fits.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset (asserted when 0)
- rx_done  input  1  one-cycle strobe: rx_data holds a valid received byte
- rx_data  input  8  received ASCII byte
- query_pulse  output  1  one-cycle pulse on a valid "TIME?" line
- run_pulse  output  1  one-cycle pulse on a valid "RUN" line
- stop_pulse  output  1  one-cycle pulse on a valid "STOP" line
- clr_pulse  output  1  one-cycle pulse on a valid "CLR" line
- set_valid  output  1  one-cycle pulse on a valid SET line
- set_bcd  output  32  {H1,H0,M1,M0,S1,S0,C1,C0}, 4 bits each, MSB = H1
- cmd_err  output  1  one-cycle pulse on an unknown, malformed, out-of-range or overflowed line
- busy  output  1  high while in CHECK or RESP

Behaviour:
- Reset (rst=0, async): state=COLLECT, len=0, ovf=0. All pulses 0, set_bcd=0, busy=0.
- COLLECT:
  - rx_done with '\r' (0x0D): ignored.
  - rx_done with '\n' (0x0A): go to CHECK.
  - Any other byte with len<MAX_LEN: buf[len]=byte, len++.
  - Any other byte with len==MAX_LEN: ovf=1, go to DISCARD.
- DISCARD: all bytes ignored until '\n', then go to CHECK.
- CHECK (one cycle, busy=1): compares buf[0..len-1] against the command templates and registers the result. Exact length match is required, so no trailing spaces and no prefix matches.
  - SET template: "SET " then 2 digits ':' 2 digits ':' 2 digits ':' 2 digits, len=15, digits '0'..'9'.
  - SET range rules: HH 00-23, MM 00-59, SS 00-59, CC 00-99.
- RESP (one cycle, busy=1): exactly one output pulses.
  - Matched command: its pulse.
  - SET passing range check: set_valid, and set_bcd loads the digits (ASCII minus 0x30) in the same cycle.
  - ovf=1, no match, bad digit, or out of range: cmd_err.
  - Empty line (len=0, ovf=0): no pulse.
  - Then len=0, ovf=0, go to COLLECT.
- Latency: rx_done carrying '\n' at cycle N gives the pulse at cycle N+2.
- set_bcd holds its value until the next valid SET. A rejected SET leaves it unchanged.
- rx_done during CHECK or RESP: byte dropped, no error. The UART byte rate makes this impossible in system use.
- Mutual exclusion: at most one pulse output is high in any cycle.
- Reset mid-line: partial line discarded, no pulse emitted.

Optional Feature:
- Macro CASE_FOLD_EN.
- Defined: bytes 'a'..'z' are converted to upper case before storage, so "time?", "Set 01:02:03:04" and "run" are accepted.
- Undefined: lower-case letters are stored as-is, and such lines produce cmd_err.

Test Plan:
- Send "TIME?\n" -> query_pulse=1 for exactly one cycle at N+2 after the '\n' rx_done; no other output pulses.
- Send "SET 23:59:58:99\r\n" -> set_valid pulse, set_bcd=32'h23595899. Then "SET 24:00:00:00\n" -> cmd_err pulse, set_bcd stays 32'h23595899.
- Send "RUN\n", "STOP\n", "CLR\n" back-to-back -> run_pulse, stop_pulse, clr_pulse once each, in order. Send "RUNX\n" and "\n" -> one cmd_err, nothing for the empty line.
- Send 20 'A' bytes then "\n" (MAX_LEN=16) -> single cmd_err. A following "TIME?\n" -> query_pulse (buffer recovered).
- Send "SET 12:3", drive rst=0 for 2 cycles, then send "STOP\n" -> no pulse from the partial line, then stop_pulse; set_bcd=0.
- With CASE_FOLD_EN: "time?\n" -> query_pulse. Without it: "time?\n" -> cmd_err.

Source files
------------

// File: rtl/ascii_cmd_receiver_if.sv
// ascii_cmd_receiver_if: connects the UART RX byte stream and the decoded command
// outputs of ascii_cmd_receiver.
//   rx_done, rx_data      received-byte strobe and byte (from the UART)
//   query/run/stop/clr    one-cycle command pulses
//   set_valid, set_bcd    accepted SET pulse and its 8-digit BCD time
//   cmd_err               one-cycle pulse for a rejected line
//   busy                  receiver is deciding or reporting a line
// Modports: slave = the receiver, master = the byte source / command consumer.
interface ascii_cmd_receiver_if;
    logic        rx_done;
    logic [7:0]  rx_data;
    logic        query_pulse;
    logic        run_pulse;
    logic        stop_pulse;
    logic        clr_pulse;
    logic        set_valid;
    logic [31:0] set_bcd;
    logic        cmd_err;
    logic        busy;

    modport slave (
        input  rx_done, rx_data,
        output query_pulse, run_pulse, stop_pulse, clr_pulse,
               set_valid, set_bcd, cmd_err, busy
    );

    modport master (
        output rx_done, rx_data,
        input  query_pulse, run_pulse, stop_pulse, clr_pulse,
               set_valid, set_bcd, cmd_err, busy
    );
endinterface

// File: rtl/ascii_cmd_receiver.sv
// ascii_cmd_receiver: line-oriented ASCII command parser.
// Gathers UART bytes into a line buffer. On '\n' the line is decoded as one of
// "TIME?", "RUN", "STOP", "CLR" or "SET HH:MM:SS:CC", and one result pulse is
// issued two cycles after the '\n' strobe.
// Ports:
//   clk   system clock
//   rst   asynchronous reset, active low
//   bus   ascii_cmd_receiver_if.slave (rx byte input, command pulses, set_bcd, busy)
// Parameter MAX_LEN: line buffer depth in bytes, excluding '\n'. It must be at
// least 15 so that a SET line fits.
// Optional build macro CASE_FOLD_EN: if defined, 'a'..'z' are stored as upper case.
//
// state   | meaning
// COLLECT | storing line bytes, waiting for '\n'
// DISCARD | line overflowed, dropping bytes until '\n'
// CHECK   | decoding the buffered line (busy)
// RESP    | result pulse is on the outputs, line state is cleared (busy)
module ascii_cmd_receiver #(
    parameter int MAX_LEN = 16
) (
    input logic                 clk,
    input logic                 rst,
    ascii_cmd_receiver_if.slave bus
);
    localparam int LW = $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {COLLECT, DISCARD, CHECK, RESP} state_t;

    state_t        state;
    logic [LW-1:0] len;
    logic          ovf;
    logic [7:0]    line_buf [MAX_LEN];
    logic [7:0]    byte_in;
    logic          is_cr;
    logic          is_lf;
    logic          full;

    always_comb begin
        byte_in = bus.rx_data;
`ifdef CASE_FOLD_EN
        if (bus.rx_data >= "a" && bus.rx_data <= "z") begin
            byte_in = bus.rx_data - 8'h20;
        end
`endif
    end

    assign is_cr = (bus.rx_data == 8'h0D);
    assign is_lf = (bus.rx_data == 8'h0A);
    assign full  = (len == LW'(MAX_LEN));

    // The buffer contents need no reset: len decides which entries are valid.
    always_ff @(posedge clk) begin
        if (state == COLLECT && bus.rx_done && !is_cr && !is_lf && !full) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                if (len == LW'(i)) begin
                    line_buf[i] <= byte_in;
                end
            end
        end
    end

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= "0") && (c <= "9");
    endfunction

    logic        m_time;
    logic        m_run;
    logic        m_stop;
    logic        m_clr;
    logic        set_fmt;
    logic        set_rng;
    logic [31:0] set_digits;

    always_comb begin
        m_time = (len == LW'(5)) &&
                 ({line_buf[0], line_buf[1], line_buf[2], line_buf[3], line_buf[4]} == "TIME?");
        m_run  = (len == LW'(3)) && ({line_buf[0], line_buf[1], line_buf[2]} == "RUN");
        m_stop = (len == LW'(4)) &&
                 ({line_buf[0], line_buf[1], line_buf[2], line_buf[3]} == "STOP");
        m_clr  = (len == LW'(3)) && ({line_buf[0], line_buf[1], line_buf[2]} == "CLR");

        set_fmt = (len == LW'(15)) &&
                  ({line_buf[0], line_buf[1], line_buf[2], line_buf[3]} == "SET ") &&
                  (line_buf[6] == ":") && (line_buf[9] == ":") && (line_buf[12] == ":") &&
                  is_digit(line_buf[4])  && is_digit(line_buf[5])  &&
                  is_digit(line_buf[7])  && is_digit(line_buf[8])  &&
                  is_digit(line_buf[10]) && is_digit(line_buf[11]) &&
                  is_digit(line_buf[13]) && is_digit(line_buf[14]);

        // For '0'..'9' the low nibble of the ASCII code is the digit value.
        set_digits = {line_buf[4][3:0],  line_buf[5][3:0],
                      line_buf[7][3:0],  line_buf[8][3:0],
                      line_buf[10][3:0], line_buf[11][3:0],
                      line_buf[13][3:0], line_buf[14][3:0]};

        // Hours 00-23, minutes and seconds 00-59. Any two digits are valid hundredths.
        set_rng = ((set_digits[31:28] < 4'd2) ||
                   (set_digits[31:28] == 4'd2 && set_digits[27:24] <= 4'd3)) &&
                  (set_digits[23:20] <= 4'd5) &&
                  (set_digits[15:12] <= 4'd5);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= COLLECT;
            len             <= '0;
            ovf             <= 1'b0;
            bus.query_pulse <= 1'b0;
            bus.run_pulse   <= 1'b0;
            bus.stop_pulse  <= 1'b0;
            bus.clr_pulse   <= 1'b0;
            bus.set_valid   <= 1'b0;
            bus.set_bcd     <= '0;
            bus.cmd_err     <= 1'b0;
            bus.busy        <= 1'b0;
        end else begin
            bus.query_pulse <= 1'b0;
            bus.run_pulse   <= 1'b0;
            bus.stop_pulse  <= 1'b0;
            bus.clr_pulse   <= 1'b0;
            bus.set_valid   <= 1'b0;
            bus.cmd_err     <= 1'b0;

            case (state)
                COLLECT: begin
                    if (bus.rx_done) begin
                        if (is_lf) begin
                            state    <= CHECK;
                            bus.busy <= 1'b1;
                        end else if (!is_cr) begin
                            if (!full) begin
                                len <= len + LW'(1);
                            end else begin
                                ovf   <= 1'b1;
                                state <= DISCARD;
                            end
                        end
                    end
                end
                DISCARD: begin
                    if (bus.rx_done && is_lf) begin
                        state    <= CHECK;
                        bus.busy <= 1'b1;
                    end
                end
                CHECK: begin
                    // The pulse is registered here, so it appears during RESP.
                    state <= RESP;
                    if (ovf) begin
                        bus.cmd_err <= 1'b1;
                    end else if (len == '0) begin
                        // An empty line gives no pulse.
                    end else if (m_time) begin
                        bus.query_pulse <= 1'b1;
                    end else if (m_run) begin
                        bus.run_pulse <= 1'b1;
                    end else if (m_stop) begin
                        bus.stop_pulse <= 1'b1;
                    end else if (m_clr) begin
                        bus.clr_pulse <= 1'b1;
                    end else if (set_fmt && set_rng) begin
                        bus.set_valid <= 1'b1;
                        bus.set_bcd   <= set_digits;
                    end else begin
                        bus.cmd_err <= 1'b1;
                    end
                end
                RESP: begin
                    state    <= COLLECT;
                    bus.busy <= 1'b0;
                    len      <= '0;
                    ovf      <= 1'b0;
                end
                default: state <= COLLECT;
            endcase
        end
    end
endmodule

// File: tb/tb_ascii_cmd_receiver.sv
// tb_ascii_cmd_receiver: directed and random lines for ascii_cmd_receiver. A
// line-level model computes the expected pulse and set_bcd for each line.
module tb_ascii_cmd_receiver;
    localparam int MAX_LEN = 16;
    localparam int C_NONE = 0, C_QUERY = 1, C_RUN = 2, C_STOP = 3, C_CLR = 4,
                   C_SET = 5, C_ERR = 6;

    typedef byte unsigned bq_t[$];

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] exp_bcd = '0;

    ascii_cmd_receiver_if bus ();

    ascii_cmd_receiver #(.MAX_LEN(MAX_LEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [5:0] pulses();
        return {bus.query_pulse, bus.run_pulse, bus.stop_pulse,
                bus.clr_pulse, bus.set_valid, bus.cmd_err};
    endfunction

    function automatic logic [5:0] onehot(input int code);
        case (code)
            C_QUERY: return 6'b100000;
            C_RUN:   return 6'b010000;
            C_STOP:  return 6'b001000;
            C_CLR:   return 6'b000100;
            C_SET:   return 6'b000010;
            C_ERR:   return 6'b000001;
            default: return 6'b000000;
        endcase
    endfunction

    always @(negedge clk) begin
        if (rst === 1'b1) chk("mutex", 32'($countones(pulses()) <= 1), 32'd1);
    end

    function automatic bq_t s2q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    function automatic bit match(input bq_t f, input string t);
        if (f.size() != t.len()) return 1'b0;
        for (int i = 0; i < t.len(); i++) if (f[i] != t[i]) return 1'b0;
        return 1'b1;
    endfunction

    // Line-level reference: the expected outcome from the text of the line alone.
    function automatic int model(input bq_t q, output logic [31:0] bcd);
        bq_t f;
        int  dp[8] = '{4, 5, 7, 8, 10, 11, 13, 14};
        int  v[8];
        bit  ok;
        bcd = '0;
        if (q.size() > MAX_LEN) return C_ERR;
        if (q.size() == 0) return C_NONE;
        f = q;
`ifdef CASE_FOLD_EN
        for (int i = 0; i < f.size(); i++) if (f[i] >= 97 && f[i] <= 122) f[i] = f[i] - 8'd32;
`endif
        if (match(f, "TIME?")) return C_QUERY;
        if (match(f, "RUN"))   return C_RUN;
        if (match(f, "STOP"))  return C_STOP;
        if (match(f, "CLR"))   return C_CLR;
        if (f.size() != 15) return C_ERR;
        ok = (f[0] == "S") && (f[1] == "E") && (f[2] == "T") && (f[3] == " ") &&
             (f[6] == ":") && (f[9] == ":") && (f[12] == ":");
        for (int i = 0; i < 8; i++) begin
            if (f[dp[i]] < 48 || f[dp[i]] > 57) ok = 1'b0;
            v[i] = int'(f[dp[i]]) - 48;
        end
        if (!ok) return C_ERR;
        if (v[0] * 10 + v[1] > 23 || v[2] * 10 + v[3] > 59 || v[4] * 10 + v[5] > 59) return C_ERR;
        for (int i = 0; i < 8; i++) bcd = (bcd << 4) | 32'(v[i]);
        return C_SET;
    endfunction

    task automatic send_byte(input byte unsigned b);
        bus.rx_data = b;
        bus.rx_done = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_done = 1'b0;
    endtask

    // Sends body (+ optional '\r') + '\n' and checks the two cycles that follow.
    task automatic send_line(input bq_t body, input bit add_cr, input bit gaps);
        int          code;
        logic [31:0] nb;
        for (int i = 0; i < body.size(); i++) begin
            send_byte(body[i]);
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        if (add_cr) send_byte(8'h0D);
        code = model(body, nb);
        if (code == C_SET) exp_bcd = nb;
        send_byte(8'h0A);
        chk("busy_in_check", 32'(bus.busy), 32'd1);
        chk("no_pulse_n+1", 32'(pulses()), 32'd0);
        @(posedge clk); #1;
        chk("pulse_n+2", 32'(pulses()), 32'(onehot(code)));
        chk("busy_in_resp", 32'(bus.busy), 32'd1);
        chk("set_bcd", bus.set_bcd, exp_bcd);
        @(posedge clk); #1;
        chk("pulse_cleared", 32'(pulses()), 32'd0);
        chk("busy_cleared", 32'(bus.busy), 32'd0);
    endtask

    task automatic reset_check();
        chk("rst_pulses", 32'(pulses()), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_set_bcd", bus.set_bcd, 32'd0);
    endtask

    initial begin
        bq_t   q;
        string s;
        string cmds[4] = '{"TIME?", "RUN", "STOP", "CLR"};
        int    kind;

        rst = 1'b0;
        bus.rx_done = 1'b0;
        bus.rx_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        reset_check();
        rst = 1'b1;
        @(posedge clk); #1;

        send_line(s2q("TIME?"), 1'b0, 1'b0);
        send_line(s2q("SET 23:59:58:99"), 1'b1, 1'b0);
        send_line(s2q("SET 24:00:00:00"), 1'b0, 1'b0);
        send_line(s2q("SET 00:60:00:00"), 1'b0, 1'b0);
        send_line(s2q("SET 20:00:59:00"), 1'b0, 1'b0);
        send_line(s2q("SET 1a:00:00:00"), 1'b0, 1'b0);
        send_line(s2q("SET 23:59:58:99"), 1'b0, 1'b0);
        send_line(s2q("RUN"), 1'b0, 1'b0);
        send_line(s2q("STOP"), 1'b0, 1'b0);
        send_line(s2q("CLR"), 1'b0, 1'b0);
        send_line(s2q("RUNX"), 1'b0, 1'b0);
        send_line(s2q(""), 1'b0, 1'b0);
        send_line(s2q("RUN "), 1'b0, 1'b0);
        send_line(s2q("AAAAAAAAAAAAAAAAAAAA"), 1'b0, 1'b0);
        send_line(s2q("AAAAAAAAAAAAAAAA"), 1'b0, 1'b0);
        send_line(s2q("AAAAAAAAAAAAAAAAA"), 1'b0, 1'b0);
        send_line(s2q("TIME?"), 1'b0, 1'b0);
        send_line(s2q("time?"), 1'b0, 1'b0);
        send_line(s2q("Set 01:02:03:04"), 1'b0, 1'b0);

        // Partial line, then an asynchronous reset in the middle of it.
        q = s2q("SET 12:3");
        for (int i = 0; i < q.size(); i++) send_byte(q[i]);
        rst = 1'b0;
        #1;
        reset_check();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_bcd = '0;
        send_line(s2q("STOP"), 1'b0, 1'b0);

        for (int n = 0; n < 150; n++) begin
            kind = int'($urandom_range(0, 7));
            q = {};
            case (kind)
                0, 1, 2, 3: q = s2q(cmds[kind]);
                4, 5: begin
                    s = $sformatf("SET %02d:%02d:%02d:%02d", $urandom_range(0, 25),
                                  $urandom_range(0, 61), $urandom_range(0, 61),
                                  $urandom_range(0, 99));
                    q = s2q(s);
                    if ($urandom_range(0, 5) == 0)
                        q[$urandom_range(0, 14)] = byte'($urandom_range(32, 126));
                end
                6: repeat ($urandom_range(0, 20)) q.push_back(byte'($urandom_range(32, 126)));
                default: begin
                    q = s2q(cmds[$urandom_range(0, 3)]);
                    for (int i = 0; i < q.size(); i++)
                        if (q[i] >= 65 && q[i] <= 90 && $urandom_range(0, 1) == 1) q[i] = q[i] + 8'd32;
                end
            endcase
            send_line(q, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
